// File: rtl/seq_controller.sv
// seq_controller
//   Start/done sequencer for the accumulator datapath. A job is accepted in
//   IDLE. It then runs rep+1 passes of LOAD/EXEC/STORE, pulses done for one
//   cycle and returns to IDLE. In chained mode the operand load is skipped
//   after the first pass.
//
//   state | meaning
//   IDLE  | ready, waiting for start
//   LOAD  | enA: load operand register A
//   EXEC  | enALU: ALU evaluate/latch
//   STORE | enC: store result C, then finish or start the next pass
//   DONE  | one-cycle done pulse
//
// Ports
//   CLKb              clock, rising edge
//   RSTb              asynchronous reset, active low
//   start             job request, accepted when ready=1
//   op/rep/chain      job parameters, captured on accept
//   hold              stall in LOAD/EXEC/STORE, enables forced low
//   abort             cancel current job (priority over hold)
//   enA/enALU/enC     datapath register/ALU enables
//   alu_op            registered operation code
//   ready/done        handshake status
//   iter              current pass index
module seq_controller #(
  parameter int OPW  = 3,
  parameter int CNTW = 4
) (
  input  logic            CLKb,
  input  logic            RSTb,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [CNTW-1:0] rep,
  input  logic            chain,
  input  logic            hold,
  input  logic            abort,
  output logic            enA,
  output logic            enALU,
  output logic            enC,
  output logic [OPW-1:0]  alu_op,
  output logic            ready,
  output logic            done,
  output logic [CNTW-1:0] iter
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [OPW-1:0]  r_alu_op;
  logic [CNTW-1:0] r_rep;
  logic            r_chain;
  logic [CNTW-1:0] r_iter;

  logic w_busy;
  logic w_accept;
  logic w_abort;
  logic w_stall;
  logic w_last;

  assign w_busy   = (r_state == S_LOAD) || (r_state == S_EXEC) || (r_state == S_STORE);
  assign w_accept = start && (r_state == S_IDLE);
  assign w_abort  = abort && w_busy;
  // abort outranks hold for state/iter updates; hold still gates the enables
  assign w_stall  = hold && w_busy && !abort;
  assign w_last   = (r_iter == r_rep);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_EXEC;
      S_EXEC:  w_next = S_STORE;
      S_STORE: begin
        if (w_last)       w_next = S_DONE;
        else if (r_chain) w_next = S_EXEC;
        else              w_next = S_LOAD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort)      w_next = S_IDLE;
    else if (w_stall) w_next = r_state;
  end

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_state  <= S_IDLE;
      r_alu_op <= '0;
      r_rep    <= '0;
      r_chain  <= 1'b0;
      r_iter   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_alu_op <= op;
        r_rep    <= rep;
        r_chain  <= chain;
        r_iter   <= '0;
      end else if (w_abort) begin
        r_iter <= '0;
      end else if (!w_stall && (r_state == S_STORE) && !w_last) begin
        r_iter <= r_iter + CNTW'(1);
      end else if (r_state == S_DONE) begin
        // final pass index stays visible during DONE, cleared entering IDLE
        r_iter <= '0;
      end
    end
  end

  assign enA    = (r_state == S_LOAD)  && !hold;
  assign enALU  = (r_state == S_EXEC)  && !hold;
  assign enC    = (r_state == S_STORE) && !hold;
  assign ready  = (r_state == S_IDLE);
  assign done   = (r_state == S_DONE);
  assign alu_op = r_alu_op;
  assign iter   = r_iter;

endmodule

// File: tb/tb_seq_controller.sv
module tb_seq_controller;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic       CLKb = 1'b0;
  logic       RSTb;
  logic       start, chain, hold, abort;
  logic [2:0] op;
  logic [3:0] rep;
  logic       enA, enALU, enC, ready, done;
  logic [2:0] alu_op;
  logic [3:0] iter;

  int checks   = 0;
  int failures = 0;
  int en_a_cnt = 0;
  logic [2:0]  last_op = 3'd0;
  logic [11:0] sb[$];

  always #5 CLKb = ~CLKb;

  seq_controller #(.OPW(3), .CNTW(4)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .start(start), .op(op), .rep(rep),
    .chain(chain), .hold(hold), .abort(abort), .enA(enA), .enALU(enALU),
    .enC(enC), .alu_op(alu_op), .ready(ready), .done(done), .iter(iter)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {ready, done, enA, enALU, enC, alu_op, iter}
  function automatic logic [11:0] exp_vec(input logic [2:0] st, input logic [3:0] it,
                                          input logic gated);
    return {st == ST_IDLE, st == ST_DONE,
            (st == ST_LOAD) && !gated, (st == ST_EXEC) && !gated,
            (st == ST_STORE) && !gated, last_op, it};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {ready, done, enA, enALU, enC, alu_op, iter};
  endfunction

  // One clock cycle: drive inputs at the falling edge, push the expectation,
  // then pop and compare shortly after.
  task automatic cyc(input logic s, input logic h, input logic a,
                     input logic [2:0] op_i, input logic [3:0] rep_i, input logic ch_i,
                     input logic [2:0] st, input logic [3:0] it, input logic gated);
    @(negedge CLKb);
    start = s; hold = h; abort = a; op = op_i; rep = rep_i; chain = ch_i;
    sb.push_back(exp_vec(st, it, gated));
    #1;
    chk("cycle", {20'd0, obs_vec()}, {20'd0, sb.pop_front()});
    if (enA) en_a_cnt++;
  endtask

  task automatic play_job(input logic [2:0] op_i, input logic [3:0] rep_i, input logic ch,
                          input int hold_step, input int hold_len,
                          input int abort_step, input logic abort_hold,
                          input logic busy_start);
    logic [2:0] st_q[$];
    logic [3:0] it_q[$];
    int  n, len;
    bit  aborted;
    n = int'(rep_i) + 1;
    for (int p = 0; p < n; p++) begin
      if (p == 0 || !ch) begin st_q.push_back(ST_LOAD); it_q.push_back(4'(p)); end
      st_q.push_back(ST_EXEC);  it_q.push_back(4'(p));
      st_q.push_back(ST_STORE); it_q.push_back(4'(p));
    end
    st_q.push_back(ST_DONE); it_q.push_back(rep_i);

    cyc(1'b1, 1'b0, 1'b0, op_i, rep_i, ch, ST_IDLE, 4'd0, 1'b0);
    last_op  = op_i;
    en_a_cnt = 0;
    len      = 0;
    aborted  = 0;
    for (int s = 0; s < st_q.size(); s++) begin
      if (s == hold_step)
        for (int k = 0; k < hold_len; k++) begin
          cyc(busy_start, 1'b1, 1'b0, ~op_i, ~rep_i, ~ch, st_q[s], it_q[s], 1'b1);
          len++;
        end
      if (s == abort_step) begin
        cyc(busy_start, abort_hold, 1'b1, ~op_i, ~rep_i, ~ch, st_q[s], it_q[s], abort_hold);
        aborted = 1;
        break;
      end
      cyc(busy_start, 1'b0, 1'b0, ~op_i, ~rep_i, ~ch, st_q[s], it_q[s], 1'b0);
      len++;
    end
    cyc(1'b0, 1'b0, 1'b0, op_i, rep_i, ch, ST_IDLE, 4'd0, 1'b0);
    if (!aborted) begin
      chk("job_len", len, (ch ? 2 * n + 2 : 3 * n + 1) + hold_len);
      chk("enA_count", en_a_cnt, ch ? 1 : n);
    end
  endtask

  initial begin
    RSTb = 1'b0; start = 0; hold = 0; abort = 0; op = 3'd7; rep = 4'd0; chain = 0;
    #3;
    chk("reset_state", {20'd0, obs_vec()}, {20'd0, exp_vec(ST_IDLE, 4'd0, 1'b0)});
    start = 1;
    repeat (2) @(posedge CLKb);
    #1;
    chk("reset_ignores_start", {20'd0, obs_vec()}, {20'd0, exp_vec(ST_IDLE, 4'd0, 1'b0)});
    @(negedge CLKb);
    start = 0;
    RSTb  = 1'b1;

    play_job(3'b101, 4'd0, 1'b0, -1, 0, -1, 1'b0, 1'b0);  // single pass
    play_job(3'b011, 4'd2, 1'b0, -1, 0, -1, 1'b0, 1'b0);  // 3 passes, 10 cycles
    play_job(3'b110, 4'd3, 1'b1, -1, 0, -1, 1'b0, 1'b0);  // chained, 10 cycles
    play_job(3'b001, 4'd1, 1'b0,  1, 2, -1, 1'b0, 1'b0);  // hold 2 in first EXEC
    play_job(3'b010, 4'd4, 1'b0, -1, 0,  5, 1'b0, 1'b1);  // abort at 2nd STORE
    play_job(3'b100, 4'd4, 1'b0, -1, 0,  2, 1'b1, 1'b1);  // abort with hold
    play_job(3'b111, 4'd15, 1'b1, 4, 1, -1, 1'b0, 1'b1);  // max passes, no wrap
    play_job(3'b000, 4'd2, 1'b1,  0, 3, -1, 1'b0, 1'b0);  // hold in LOAD

    // asynchronous reset between edges while in EXEC
    cyc(1'b1, 1'b0, 1'b0, 3'b110, 4'd2, 1'b0, ST_IDLE, 4'd0, 1'b0);
    last_op = 3'b110;
    cyc(1'b0, 1'b0, 1'b0, 3'b110, 4'd2, 1'b0, ST_LOAD, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 3'b110, 4'd2, 1'b0, ST_EXEC, 4'd0, 1'b0);
    #1;
    RSTb = 1'b0;
    #1;
    chk("rst_enables", {enA, enALU, enC}, 3'b000);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_iter", iter, 4'd0);
    last_op = 3'd0;
    @(negedge CLKb);
    RSTb = 1'b1;
    play_job(3'b010, 4'd0, 1'b0, -1, 0, -1, 1'b0, 1'b0);  // 4-cycle job after reset

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised multi-step datapath sequencer driving the register/ALU enables (enA, enALU, enC) of the accumulator datapath. It replaces the free-running two-phase toggle with a start/done handshake, an opcode register, and a programmable iteration count. It also adds a chained (accumulate) mode that skips the operand load after the first pass, plus hold and abort controls. It sits between the instruction/front-end logic and the datapath register enables.

## Interface
- OPW, 3, width of the ALU operation code
- CNTW, 4, width of the iteration count; a job runs up to 2^CNTW passes
- CLKb  in  1  clock; all state updates on the rising edge
- RSTb  in  1  reset, asynchronous, active-low
- start  in  1  job request; accepted on a rising edge where start=1 and ready=1
- op  in  OPW  ALU operation, captured on accept
- rep  in  CNTW  pass count minus one, captured on accept (0 means 1 pass)
- chain  in  1  accumulate mode, captured on accept
- hold  in  1  stall; freezes the FSM in LOAD/EXEC/STORE
- abort  in  1  synchronous cancel of the current job
- enA  out  1  load operand register A
- enALU  out  1  ALU evaluate/latch
- enC  out  1  store result register C
- alu_op  out  OPW  registered op to the ALU
- ready  out  1  idle and able to accept a job
- done  out  1  one-cycle completion pulse
- iter  out  CNTW  index of the current pass

## Operation
- States: IDLE, LOAD, EXEC, STORE, DONE. Moore outputs decoded from state.
- IDLE: ready=1, all enables 0. On accept, the FSM registers op→alu_op, rep, and chain, clears iter to 0, and goes to LOAD.
- LOAD: enA=1 → EXEC.
- EXEC: enALU=1 → STORE.
- STORE: enC=1.
  - If iter==rep_reg → DONE.
  - Otherwise iter+1. Next state is EXEC if chain_reg=1, LOAD if chain_reg=0.
- DONE: done=1 → IDLE. iter holds its final value during DONE and clears to 0 on entry to IDLE.
- At most one of enA/enALU/enC is high in any cycle.
- hold=1 in LOAD/EXEC/STORE: state, iter, and registers are frozen, and all three enables are forced 0. hold has no effect in IDLE or DONE.
- abort=1 in LOAD/EXEC/STORE: next state is IDLE, no done pulse, and iter is cleared. abort has priority over hold. abort is ignored in IDLE and DONE.
- start while ready=0 is ignored and not queued. op/rep/chain changes while busy have no effect.
- iter compare is an unsigned CNTW-bit equality, so rep=2^CNTW−1 runs 2^CNTW passes with no wrap.

## Timing
- Reset values (RSTb low, asynchronous):
  - state=IDLE
  - ready=1
  - enA=enALU=enC=0
  - done=0
  - alu_op=0, iter=0
  - internal rep/chain registers=0
- Reset mid-job returns to IDLE immediately with no done pulse.
- Accept at edge k puts the FSM in LOAD for the cycle after edge k.
- Job length, with N=rep+1 and counting from the first LOAD cycle up to and including the done cycle:
  - chain=0: 3N+1 cycles
  - chain=1: 2N+2 cycles
- Every hold cycle adds exactly 1 to the job length.
- ready is low from the cycle after accept through the DONE cycle. The earliest next accept is the edge ending the first IDLE cycle after DONE.
- done is high for exactly one cycle per completed job.

## Test plan
- Reset, then start=1 with op=3'b101, rep=0, chain=0:
  - Enables are enA, enALU, enC in consecutive cycles, then done=1 for one cycle.
  - alu_op=5 throughout the job.
  - ready returns to 1 after the DONE cycle.
- rep=2, chain=0:
  - The LOAD/EXEC/STORE sequence repeats 3 times, with iter = 0, 1, 2.
  - The job takes 10 cycles including DONE.
- rep=3, chain=1:
  - Sequence is LOAD, then EXEC/STORE ×4, then DONE, for 10 cycles in total.
  - enA is high exactly once.
- rep=1, chain=0, with hold=1 for 2 cycles during the first EXEC:
  - EXEC lasts 3 cycles, with enALU=0 during the held cycles.
  - Total job is 9 cycles, and done still pulses once.
- Two aborts plus a start during an aborted job, rep=4:
  - First abort during the second STORE: next cycle is IDLE, ready=1, iter=0, done never asserted.
  - Restart the job and assert abort together with hold: abort wins.
  - start pulses while busy are ignored.
- Assert RSTb low mid-EXEC (asynchronous, between edges):
  - All enables drop to 0 immediately, ready=1, alu_op=0.
  - After release, a new job with rep=0 completes in 4 cycles.
